// File: rtl/nonce_dispatch.sv
// Buffers rng nonces in a small FIFO and issues them to the hash core under a per-job
// budget with early stop on found. Optional counters: define NONCE_DISPATCH_STATS_EN.
module nonce_dispatch #(
  parameter int WORDSIZE   = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    max_nonces,
  input  logic [WORDSIZE-1:0] rng_data,
  input  logic                rng_ready,
  output logic                rng_en,
  output logic [WORDSIZE-1:0] nonce_data,
  output logic                nonce_valid,
  input  logic                nonce_ready,
  input  logic                found,
  input  logic [WORDSIZE-1:0] found_nonce,
  output logic                busy,
  output logic                done,
  output logic                success,
  output logic [WORDSIZE-1:0] result
`ifdef NONCE_DISPATCH_STATS_EN
  ,
  output logic [CNT_W-1:0]    issued_cnt,
  output logic [CNT_W-1:0]    stall_cnt
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_FW = PTR_W + 1;
  localparam logic [CNT_FW-1:0] DEPTH_C = CNT_FW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WORDSIZE-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_FW-1:0]   count;
  logic [CNT_W-1:0]    remaining;

  logic active;
  logic fifo_empty;
  logic fifo_full;
  logic accept;
  logic pull;
  logic hit;
  logic flush;
  logic xfer;
  logic pop;

  assign active     = (state == RUN) || (state == DRAIN);
  assign fifo_empty = (count == '0);
  // Registered count only: a pop in the same cycle never makes room for a push.
  assign fifo_full  = (count == DEPTH_C);
  assign hit        = found & active;
  assign flush      = accept | hit;
  assign xfer       = nonce_valid & nonce_ready;
  assign pop        = xfer & ~hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    pull      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (max_nonces == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (found) begin
          state_nxt = DONE;
        end else begin
          pull = rng_ready & ~fifo_full & (remaining != '0);
          if (pull && (remaining == CNT_W'(1))) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (found || fifo_empty) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (pull) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_FW'(pull) - CNT_FW'(pop);
    end
  end

  // Storage needs no reset: nonce_data is gated by valid, and valid follows count.
  always_ff @(posedge clk) begin
    if (pull) begin
      mem[wr_ptr] <= rng_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining <= '0;
    end else if (accept) begin
      remaining <= max_nonces;
    end else if (pull) begin
      remaining <= remaining - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      success <= 1'b0;
      result  <= '0;
    end else if (accept) begin
      success <= 1'b0;
      result  <= '0;
    end else if (hit) begin
      success <= 1'b1;
      result  <= found_nonce;
    end
  end

  assign rng_en      = pull;
  assign nonce_valid = ~fifo_empty & active;
  assign nonce_data  = nonce_valid ? mem[rd_ptr] : '0;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

`ifdef NONCE_DISPATCH_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued_cnt <= '0;
    end else if (accept) begin
      issued_cnt <= '0;
    end else if (xfer && !(&issued_cnt)) begin
      issued_cnt <= issued_cnt + CNT_W'(1);
    end
  end

  // nonce_valid already implies RUN or DRAIN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (nonce_valid && !nonce_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_nonce_dispatch.sv
// Scoreboard bench for nonce_dispatch: expected nonce stream is queued at job start
// from the rng table; a negedge monitor pops and compares on every transfer.
module tb_nonce_dispatch;
  localparam int WS = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] max_nonces = '0;
  logic [WS-1:0] rng_data;
  logic          rng_ready = 1'b0;
  logic          rng_en;
  logic [WS-1:0] nonce_data;
  logic          nonce_valid;
  logic          nonce_ready = 1'b0;
  logic          found = 1'b0;
  logic [WS-1:0] found_nonce = '0;
  logic          busy, done, success;
  logic [WS-1:0] result;
`ifdef NONCE_DISPATCH_STATS_EN
  logic [CW-1:0] issued_cnt, stall_cnt;
`endif

  nonce_dispatch #(.WORDSIZE(WS), .FIFO_DEPTH(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .max_nonces(max_nonces),
    .rng_data(rng_data), .rng_ready(rng_ready), .rng_en(rng_en),
    .nonce_data(nonce_data), .nonce_valid(nonce_valid), .nonce_ready(nonce_ready),
    .found(found), .found_nonce(found_nonce), .busy(busy), .done(done),
    .success(success), .result(result)
`ifdef NONCE_DISPATCH_STATS_EN
    , .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // rng environment: a table walked by rng_en, never rewound.
  logic [WS-1:0] rng_tab [256];
  int unsigned   rng_idx = 0;
  assign rng_data = rng_tab[rng_idx[7:0]];
  always @(posedge clk) if (rng_en) rng_idx <= rng_idx + 1;

  int n_checks = 0;
  int n_fail = 0;
  int tot_pulls = 0;
  int tot_done = 0;
  logic [WS-1:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    logic          pv;
    logic [WS-1:0] pd;
    pv = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pv = 1'b0;
      end else begin
        if (pv) begin
          chk("hold_valid", 64'(nonce_valid), 64'(1));
          chk("hold_data", 64'(nonce_data), 64'(pd));
        end
        if (rng_en) tot_pulls++;
        if (!rng_ready) chk("no_pull_without_rng_ready", 64'(rng_en), 64'(0));
        if (done) tot_done++;
        if (nonce_valid && nonce_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL xfer_unexpected: got 0x%0h, expected no transfer", nonce_data);
          end else begin
            chk("xfer_data", 64'(nonce_data), 64'(exp_q.pop_front()));
          end
        end
        pv = nonce_valid && !nonce_ready && !found;
        pd = nonce_data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int b, output int pulls0, output int done0);
    for (int k = 0; k < b; k++) exp_q.push_back(rng_tab[(rng_idx + k) % 256]);
    pulls0 = tot_pulls;
    done0 = tot_done;
    max_nonces = CW'(b);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input string nm, input int done0, input int rdy_pct,
                                input int rr_pct);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (tot_done != done0) begin
        ok = 1'b1;
        break;
      end
      nonce_ready = (int'($urandom_range(0, 99)) < rdy_pct);
      rng_ready = (int'($urandom_range(0, 99)) < rr_pct);
      step();
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done pulse, expected one within 1000 cycles", nm);
    end
  endtask

  task automatic finish_job(input string nm, input int b, input int pulls0, input int done0);
    chk({nm, "_pulls"}, 64'(tot_pulls - pulls0), 64'(b));
    chk({nm, "_queue_left"}, 64'(exp_q.size()), 64'(0));
    chk({nm, "_success"}, 64'(success), 64'(0));
    chk({nm, "_busy"}, 64'(busy), 64'(0));
    step();
    chk({nm, "_done_pulses"}, 64'(tot_done - done0), 64'(1));
  endtask

  initial begin
    int p0, d0, b;
    for (int i = 0; i < 256; i++) rng_tab[i] = (i < 32) ? WS'(i) : WS'($urandom);

    // Reset state
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_valid", 64'(nonce_valid), 64'(0));
    chk("rst_data", 64'(nonce_data), 64'(0));
    chk("rst_rng_en", 64'(rng_en), 64'(0));
    chk("rst_success", 64'(success), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    step();
    step();
    reset = 1'b1;
    step();

    // Budget of 5, no backpressure: nonces 0..4 in order
    rng_ready = 1'b1;
    nonce_ready = 1'b1;
    start_job(5, p0, d0);
    run_until_done("budget", d0, 100, 100);
    finish_job("budget", 5, p0, d0);

    // Backpressure: four pulls fill the FIFO, head holds
    rng_ready = 1'b1;
    nonce_ready = 1'b0;
    start_job(6, p0, d0);
    for (int i = 0; i < 10; i++) step();
    chk("bp_pulls", 64'(tot_pulls - p0), 64'(4));
    chk("bp_valid", 64'(nonce_valid), 64'(1));
    chk("bp_head", 64'(nonce_data), 64'(exp_q[0]));
    run_until_done("bp", d0, 100, 100);
    finish_job("bp", 6, p0, d0);

    // rng not ready in RUN
    rng_ready = 1'b0;
    nonce_ready = 1'b1;
    start_job(5, p0, d0);
    for (int i = 0; i < 8; i++) step();
    chk("rngwait_pulls", 64'(tot_pulls - p0), 64'(0));
    chk("rngwait_busy", 64'(busy), 64'(1));
    run_until_done("rngwait", d0, 100, 100);
    finish_job("rngwait", 5, p0, d0);

    // Zero budget
    rng_ready = 1'b1;
    start_job(0, p0, d0);
    chk("zero_done", 64'(done), 64'(1));
    chk("zero_busy", 64'(busy), 64'(1));
    step();
    chk("zero_done_end", 64'(done), 64'(0));
    chk("zero_busy_end", 64'(busy), 64'(0));
    chk("zero_pulls", 64'(tot_pulls - p0), 64'(0));
    chk("zero_success", 64'(success), 64'(0));

    // Early stop with three buffered nonces; found beats a same-cycle pull
    rng_ready = 1'b0;
    nonce_ready = 1'b0;
    start_job(10, p0, d0);
    rng_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rng_ready = 1'b0;
    chk("stop_pulls_before", 64'(tot_pulls - p0), 64'(3));
    rng_ready = 1'b1;
    found = 1'b1;
    found_nonce = 32'h2A;
    step();
    found = 1'b0;
    exp_q.delete();
    chk("stop_valid", 64'(nonce_valid), 64'(0));
    chk("stop_done", 64'(done), 64'(1));
    chk("stop_success", 64'(success), 64'(1));
    chk("stop_result", 64'(result), 64'(32'h2A));
    for (int i = 0; i < 4; i++) step();
    chk("stop_pulls_after", 64'(tot_pulls - p0), 64'(3));
    chk("stop_done_pulses", 64'(tot_done - d0), 64'(1));
    found = 1'b1;
    found_nonce = 32'h55;
    step();
    found = 1'b0;
    step();
    chk("idle_found_result", 64'(result), 64'(32'h2A));
    chk("idle_found_success", 64'(success), 64'(1));
    chk("idle_found_busy", 64'(busy), 64'(0));

    // Asynchronous reset mid-RUN
    start_job(20, p0, d0);
    run_until_done("pre_reset", d0 - 1, 50, 100);
    for (int i = 0; i < 4; i++) begin
      nonce_ready = (int'($urandom_range(0, 99)) < 50);
      step();
    end
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_valid", 64'(nonce_valid), 64'(0));
    chk("arst_data", 64'(nonce_data), 64'(0));
    chk("arst_rng_en", 64'(rng_en), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_success", 64'(success), 64'(0));
    chk("arst_result", 64'(result), 64'(0));
    exp_q.delete();
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    step();
    chk("arst_no_done", 64'(tot_done - d0), 64'(0));

    // Full job after reset: budget 8 with exactly three stall cycles
    rng_ready = 1'b1;
    nonce_ready = 1'b0;
    start_job(8, p0, d0);
    for (int i = 0; i < 20 && !nonce_valid; i++) step();
    chk("post_rst_valid", 64'(nonce_valid), 64'(1));
    for (int i = 0; i < 3; i++) step();
    nonce_ready = 1'b1;
    run_until_done("post_rst", d0, 100, 100);
`ifdef NONCE_DISPATCH_STATS_EN
    chk("stats_issued", 64'(issued_cnt), 64'(8));
    chk("stats_stall", 64'(stall_cnt), 64'(3));
`endif
    finish_job("post_rst", 8, p0, d0);

    // Randomized jobs
    for (int j = 0; j < 8; j++) begin
      b = int'($urandom_range(1, 12));
      start_job(b, p0, d0);
      run_until_done("rand", d0, int'($urandom_range(30, 100)), int'($urandom_range(30, 100)));
      nonce_ready = 1'b1;
      finish_job("rand", b, p0, d0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
